matrix_frame_scanner: RTL

- Downstream display stage for the game logic. Drives the 8x8 RGB LED matrix through active-low column lines position_R/G/B and a 3-bit row select S.
- Game logic writes whole rows of pixel data into a double-buffered frame store. The block then row-scans the front buffer at a fixed dwell with inter-row blanking, which removes ghosting.
- Buffer swaps happen only at frame boundaries, so the display never tears.

---
 rtl/matrix_frame_scanner.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/matrix_frame_scanner.sv
// Row-scanning driver for an 8x8 RGB LED matrix with a double-buffered frame store.
// Buffer exchanges are deferred to the frame boundary so the panel never tears.
`timescale 1ns/1ps
module matrix_frame_scanner #(
   parameter int DWELL_CYCLES = 10000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       CLK,
   input  logic       Clear,
   input  logic       wr_en,
   input  logic [2:0] wr_row,
   input  logic [7:0] wr_r,
   input  logic [7:0] wr_g,
   input  logic [7:0] wr_b,
   input  logic       swap_req,
   input  logic       blank_all,
   output logic [7:0] position_R,
   output logic [7:0] position_G,
   output logic [7:0] position_B,
   output logic [2:0] S,
   output logic       frame_start,
   output logic       swap_ack,
   output logic       swap_pending
);

   localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

   state_t        state_r, state_nx;
   logic [CW-1:0] cnt_r, cnt_nx;
   logic [2:0]    s_r, s_nx;
   logic          front_sel_r;
   logic [23:0]   bank_r [2][8];
   logic [7:0]    pos_red_r, pos_grn_r, pos_blu_r;
   logic [7:0]    red_nx, grn_nx, blu_nx;
   logic          frame_start_r, swap_ack_r, swap_pending_r;
   logic          frame_end_s, swap_commit_s, pending_nx;
   logic [23:0]   front_row_s;

   // Scan sequencer: blanking/dwell phase counting and row advance
   always_comb begin
      state_nx    = state_r;
      cnt_nx      = cnt_r + CNT_ONE;
      s_nx        = s_r;
      frame_end_s = 1'b0;
      case (state_r)
         ST_BLANK: begin
            if (cnt_r == BLANK_LAST) begin
               state_nx = ST_SHOW;
               cnt_nx   = CNT_ZERO;
            end else begin
               state_nx = ST_BLANK;
            end
         end
         ST_SHOW: begin
            if (cnt_r == DWELL_LAST) begin
               state_nx    = ST_BLANK;
               cnt_nx      = CNT_ZERO;
               s_nx        = s_r + 3'd1;
               frame_end_s = (s_r == 3'd7);
            end else begin
               state_nx = ST_SHOW;
            end
         end
         default: begin
            state_nx = ST_BLANK;
            cnt_nx   = CNT_ZERO;
            s_nx     = 3'd0;
         end
      endcase
   end

   // Swap handshake and next column drive (columns are computed for the upcoming cycle)
   always_comb begin
      swap_commit_s = frame_end_s & (swap_pending_r | swap_req);
      if (swap_commit_s) begin
         pending_nx = 1'b0;
      end else if (swap_req) begin
         pending_nx = 1'b1;
      end else begin
         pending_nx = swap_pending_r;
      end
      front_row_s = bank_r[front_sel_r][s_nx];
      if ((state_nx == ST_SHOW) && !blank_all) begin
         red_nx = ~front_row_s[23:16];
         grn_nx = ~front_row_s[15:8];
         blu_nx = ~front_row_s[7:0];
      end else begin
         red_nx = 8'hFF;
         grn_nx = 8'hFF;
         blu_nx = 8'hFF;
      end
   end

   // Control and output registers
   always_ff @(posedge CLK) begin
      if (!Clear) begin
         state_r        <= ST_BLANK;
         cnt_r          <= CNT_ZERO;
         s_r            <= 3'd0;
         front_sel_r    <= 1'b0;
         pos_red_r      <= 8'hFF;
         pos_grn_r      <= 8'hFF;
         pos_blu_r      <= 8'hFF;
         frame_start_r  <= 1'b0;
         swap_ack_r     <= 1'b0;
         swap_pending_r <= 1'b0;
      end else begin
         state_r        <= state_nx;
         cnt_r          <= cnt_nx;
         s_r            <= s_nx;
         front_sel_r    <= front_sel_r ^ swap_commit_s;
         pos_red_r      <= red_nx;
         pos_grn_r      <= grn_nx;
         pos_blu_r      <= blu_nx;
         frame_start_r  <= frame_end_s;
         swap_ack_r     <= swap_commit_s;
         swap_pending_r <= pending_nx;
      end
   end

   // Frame store; a write in the swap cycle targets the pre-swap back bank
   always_ff @(posedge CLK) begin
      if (!Clear) begin
         for (int i = 0; i < 8; i++) begin
            bank_r[0][i] <= 24'h000000;
            bank_r[1][i] <= 24'h000000;
         end
      end else if (wr_en) begin
         bank_r[~front_sel_r][wr_row] <= {wr_r, wr_g, wr_b};
      end else begin
         bank_r <= bank_r;
      end
   end

   assign position_R   = pos_red_r;
   assign position_G   = pos_grn_r;
   assign position_B   = pos_blu_r;
   assign S            = s_r;
   assign frame_start  = frame_start_r;
   assign swap_ack     = swap_ack_r;
   assign swap_pending = swap_pending_r;

endmodule
